add_sub_pipe: RTL and testbench

Registered, handshaked front end for the signed 8-bit add/subtract datapath.
- Accepts operand pairs plus an opcode on a valid/ready input.
- Computes the two's-complement add or subtract in a 2-stage pipeline, with optional saturation.
- Presents the result and overflow flag on a valid/ready output.
- Keeps a sticky overflow flag and a completed-operation counter for the downstream consumer and for debug.

---
 rtl/add_sub_pipe_if.sv | 37 +++
 rtl/add_sub_pipe.sv | 165 ++++++++++++++++
 tb/tb_add_sub_pipe.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/add_sub_pipe_if.sv
// rtl/add_sub_pipe_if.sv - operand/result handshake bundle for add_sub_pipe
//
// Purpose: groups the input channel (operands, opcode, saturation select)
// and the output channel (result, overflow) with their valid/ready pairs.
// Port summary:
//   in_valid/in_ready   : operand channel handshake
//   a, b                : signed WIDTH-bit operands
//   opcode              : 0 = a+b, 1 = a-b
//   sat                 : saturate on overflow
//   out_valid/out_ready : result channel handshake
//   sum, ovf            : signed result and its overflow flag
// Modports: slave = the arithmetic block, master = the operand source and
// result consumer.
interface add_sub_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             opcode;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, opcode, sat, out_ready,
    output in_ready, out_valid, sum, ovf
  );

  modport master (
    output in_valid, a, b, opcode, sat, out_ready,
    input  in_ready, out_valid, sum, ovf
  );
endinterface

// File: rtl/add_sub_pipe.sv
// rtl/add_sub_pipe.sv - two-stage handshaked signed add/subtract with saturation
//
// Purpose: accepts operand pairs on a valid/ready channel, registers them in
// stage 1, computes the two's-complement add or subtract (optionally
// saturated) into stage 2 and presents it on a valid/ready result channel.
// Also keeps a sticky overflow flag and a count of transferred results.
// Port summary:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bus        : add_sub_pipe_if.slave (operand and result channels)
//   clr_sticky : synchronous clear of sticky_ovf (a same-cycle set wins)
//   sticky_ovf : set by any transferred result with ovf = 1
//   op_count   : transferred results, modulo 2^CNT_W
module add_sub_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  add_sub_pipe_if.slave    bus,
  input  logic             clr_sticky,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] op_count
);

  // Stage 1: captured operands
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_op_q, s1_op_d;
  logic             s1_sat_q, s1_sat_d;

  // Stage 2: result
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_sum_q, s2_sum_d;
  logic             s2_ovf_q, s2_ovf_d;

  // Status
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Handshake events
  logic in_acc;
  logic s1_adv;
  logic out_xfer;

  // Arithmetic on stage-1 contents
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] raw;
  logic             a_msb;
  logic             b_msb;
  logic             r_msb;
  logic             ovf_c;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] res_c;

  assign out_xfer = s2_valid_q && bus.out_ready;
  // Stage 1 may move on when stage 2 is empty or being drained this cycle.
  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_xfer);
  // Combinational through out_ready so a full pipe still streams one per cycle.
  assign bus.in_ready = !s1_valid_q || s1_adv;
  assign in_acc   = bus.in_valid && bus.in_ready;

  always_comb begin
    b_eff = s1_b_q;
    if (s1_op_q) begin
      b_eff = ~s1_b_q;
    end
    // Subtract is a + ~b + 1; the +1 rides in as the opcode bit.
    raw   = s1_a_q + b_eff + {{(WIDTH-1){1'b0}}, s1_op_q};
    a_msb = s1_a_q[WIDTH-1];
    b_msb = s1_b_q[WIDTH-1];
    r_msb = raw[WIDTH-1];
    if (s1_op_q) begin
      ovf_c = (a_msb != b_msb) && (r_msb != a_msb);
    end else begin
      ovf_c = (a_msb == b_msb) && (r_msb != a_msb);
    end
    // On overflow the true result always has the sign of a.
    if (a_msb) begin
      sat_val = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(WIDTH-1){1'b1}}};
    end
    res_c = raw;
    if (s1_sat_q && ovf_c) begin
      res_c = sat_val;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_sat_d   = s1_sat_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_ovf_d   = s2_ovf_q;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;

    if (in_acc) begin
      s1_valid_d = 1'b1;
      s1_a_d     = bus.a;
      s1_b_d     = bus.b;
      s1_op_d    = bus.opcode;
      s1_sat_d   = bus.sat;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_sum_d   = res_c;
      s2_ovf_d   = ovf_c;
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end

    // Set has priority over a same-cycle clear.
    if (out_xfer && s2_ovf_q) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end

    if (out_xfer) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= 1'b0;
      s1_sat_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_ovf_q   <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_sat_q   <= s1_sat_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_ovf_q   <= s2_ovf_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.sum       = s2_sum_q;
  assign bus.ovf       = s2_ovf_q;
  assign sticky_ovf    = sticky_q;
  assign op_count      = cnt_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// tb/tb_add_sub_pipe.sv - self-checking bench for add_sub_pipe
module tb_add_sub_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_sticky = 1'b0;
  logic       sticky_ovf;
  logic [7:0] op_count;

  add_sub_pipe_if #(.WIDTH(8)) bus ();

  add_sub_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .sticky_ovf (sticky_ovf),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];   // {ovf, sum} of accepted but not yet transferred ops
  logic [7:0] cnt_m = 8'd0;
  bit         sticky_m = 1'b0;
  bit         last_acc;
  bit         last_xfer;
  int         accepts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, overflow = out of signed 8-bit range.
  function automatic logic [8:0] ref_op(input logic [7:0] a8, input logic [7:0] b8,
                                        input bit op, input bit st);
    int ia;
    int ib;
    int full;
    int res;
    bit o;
    ia = $signed(a8);
    ib = $signed(b8);
    full = op ? (ia - ib) : (ia + ib);
    o = (full > 127) || (full < -128);
    res = full;
    if (o && st) res = (full > 0) ? 127 : -128;
    return {o, res[7:0]};
  endfunction

  // One clock: drive at the negedge, observe the handshakes just before the
  // posedge, then check the status outputs at the following negedge.
  task automatic step(input bit iv, input logic [7:0] ia, input logic [7:0] ib,
                      input bit op, input bit st, input bit ordy, input bit clr);
    logic [8:0] e;
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.opcode    = op;
    bus.sat       = st;
    bus.out_ready = ordy;
    clr_sticky    = clr;
    #1;
    last_acc  = bus.in_valid && bus.in_ready;
    last_xfer = bus.out_valid && bus.out_ready;
    if (last_xfer) begin
      check("xfer_has_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sum", 32'(bus.sum), 32'(e[7:0]));
        check("ovf", 32'(bus.ovf), 32'(e[8]));
        cnt_m = cnt_m + 8'd1;
        if (e[8]) sticky_m = 1'b1;
        else if (clr) sticky_m = 1'b0;
      end
    end else if (clr) begin
      sticky_m = 1'b0;
    end
    if (last_acc) exp_q.push_back(ref_op(ia, ib, op, st));
    @(posedge clk);
    @(negedge clk);
    check("op_count", 32'(op_count), 32'(cnt_m));
    check("sticky_ovf", 32'(sticky_ovf), 32'(sticky_m));
  endtask

  task automatic drain();
    for (int k = 0; k < 6 && (exp_q.size() > 0); k++) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [7:0] r8();
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.a = 8'd0; bus.b = 8'd0; bus.opcode = 1'b0;
    bus.sat = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_sticky", 32'(sticky_ovf), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Basic ops with latency check on the first
    step(1'b1, 8'd11, 8'd33, 1'b0, 1'b0, 1'b1, 1'b0);
    check("lat_after_1_edge", 32'(bus.out_valid), 32'd0);
    step(1'b1, 8'd120, 8'd45, 1'b1, 1'b0, 1'b1, 1'b0);
    check("lat_after_2_edges", 32'(bus.out_valid), 32'd1);
    check("basic_sum0", 32'(bus.sum), 32'd44);
    step(1'b1, 8'hF6, 8'h9D, 1'b0, 1'b0, 1'b1, 1'b0);
    check("basic_sum1", 32'(bus.sum), 32'd75);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("basic_sum2", 32'(bus.sum), 32'(8'h93));
    drain();
    check("basic_op_count", 32'(op_count), 32'd3);

    // Overflow: wrap vs saturate, plus the -128 edge cases
    step(1'b1, 8'd120, 8'd45, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'd120, 8'd45, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ovf_wrap_sum", 32'(bus.sum), 32'(8'hA5));
    step(1'b1, 8'h80, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    check("ovf_sat_sum", 32'(bus.sum), 32'h7F);
    step(1'b1, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
    check("sticky_after_ovf", 32'(sticky_ovf), 32'd1);
    check("neg_sat_sum", 32'(bus.sum), 32'h80);
    step(1'b1, 8'h00, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0);
    check("zero_minus_min_wrap", 32'(bus.sum), 32'h80);
    check("zero_minus_min_ovf", 32'(bus.ovf), 32'd1);
    step(1'b1, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    check("zero_minus_min_sat", 32'(bus.sum), 32'h7F);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("min_minus_zero_ovf", 32'(bus.ovf), 32'd0);
    drain();

    // Backpressure: only two ops fit while the output is stalled
    accepts = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, r8(), r8(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (last_acc) accepts++;
    end
    check("bp_accepts", 32'(accepts), 32'd2);
    #1;
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_held_sum", 32'(bus.sum), 32'(exp_q[0][7:0]));
    check("bp_held_valid", 32'(bus.out_valid), 32'd1);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_release_xfer0", 32'(last_xfer), 32'd1);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_release_xfer1", 32'(last_xfer), 32'd1);
    check("bp_empty", 32'(bus.out_valid), 32'd0);

    // Sticky flag: set wins over a same-cycle clear
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("sticky_cleared", 32'(sticky_ovf), 32'd0);
    step(1'b1, 8'd120, 8'd45, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sticky_held_not_set", 32'(sticky_ovf), 32'd0);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("sticky_set_wins", 32'(sticky_ovf), 32'd1);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("sticky_clear_alone", 32'(sticky_ovf), 32'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), r8(), r8(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 9) == 0));
    end
    drain();

    // Reset mid-operation with two ops in flight
    step(1'b1, 8'd120, 8'd45, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    step(1'b1, r8(), r8(), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, r8(), r8(), 1'b1, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_op_count", 32'(op_count), 32'd0);
    check("mid_rst_sticky", 32'(sticky_ovf), 32'd0);
    exp_q.delete();
    cnt_m = 8'd0;
    sticky_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("no_stale_result", 32'(bus.out_valid), 32'd0);
    end

    // Counter wrap
    for (int i = 0; i < 255; i++) step(1'b1, r8(), r8(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    drain();
    check("op_count_255", 32'(op_count), 32'd255);
    step(1'b1, r8(), r8(), 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    check("op_count_wrap", 32'(op_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
